// File: rtl/imem_loader.sv
// Byte-stream program loader: writes 16-bit words into instruction memory and
// releases the CPU reset only after a length-checked, XOR-verified load.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          chk_q, chk_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                in_ready_q, busy_q, done_q, error_q, cpu_rst_n_q;
  logic                in_busy_d;
  logic                xfer;
  logic [15:0]         len_w;
  logic [15:0]         len_m1;

  assign xfer   = in_valid & in_ready_q;
  assign len_w  = {len_hi_q, in_data};
  assign len_m1 = len_w - 16'd1;

  always_comb begin
    state_d = state_q;
    len_hi_d = len_hi_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (load_start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) begin
        len_hi_d = in_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        if (len_w == 16'd0 || {1'b0, len_w} > MAX_N) begin
          state_d = S_ERR;
        end else begin
          state_d = S_DATA_HI;
          idx_d   = '0;
          chk_d   = 8'h00;
          last_d  = ADDR_W'(len_m1);
        end
      end
      S_DATA_HI: if (xfer) begin
        hi_d    = in_data;
        chk_d   = chk_q ^ in_data;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (xfer) begin
        // index wraps naturally when N fills the whole address space
        wdata_d = DATA_W'({hi_q, in_data});
        chk_d   = chk_q ^ in_data;
        we_d    = 1'b1;
        addr_d  = idx_q;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == last_q) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (xfer) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_busy_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                     (state_d == S_CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'h00;
      last_q      <= '0;
      idx_q       <= '0;
      hi_q        <= 8'h00;
      chk_q       <= 8'h00;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      chk_q       <= chk_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_busy_d;
      busy_q      <= in_busy_d;
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);
      cpu_rst_n_q <= (state_d == S_DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset_n = cpu_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
